// File: rtl/bus_dev_port_if.sv
// Host-side and bus-side handshake bundle for one device endpoint.
// The endpoint itself uses the slave modport. The host logic and the bus generator use master.
interface bus_dev_port_if #(
  parameter int pckg_sz = 16
) ();
  logic               host_wr;
  logic [pckg_sz-1:0] host_wdata;
  logic               host_full;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rx_valid;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_ready;

  modport slave (
    input  host_wr, host_wdata, pop, push, D_push, rx_ready,
    output host_full, pndng, D_pop, rx_valid, rx_data
  );

  modport master (
    output host_wr, host_wdata, pop, push, D_push, rx_ready,
    input  host_full, pndng, D_pop, rx_valid, rx_data
  );
endinterface

// File: rtl/bus_dev_port.sv
// Per-device bus endpoint with show-ahead TX and RX FIFOs, an RX address filter
// and saturating debug event counters.
module bus_dev_port #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] dev_id    = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic           clk,
  input  logic           reset,
  bus_dev_port_if.slave  bus,
  output logic [7:0]     tx_ovf_cnt,
  output logic [7:0]     rx_ovf_cnt,
  output logic [7:0]     rx_filt_cnt
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);
  localparam logic [aw-1:0] last_idx = aw'(depth - 1);
  localparam logic [cw-1:0] full_cnt = cw'(depth);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [aw-1:0]      tx_wr_ptr, tx_rd_ptr;
  logic [cw-1:0]      tx_count;

  logic [pckg_sz-1:0] rx_mem [depth];
  logic [aw-1:0]      rx_wr_ptr, rx_rd_ptr;
  logic [cw-1:0]      rx_count;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_do_pop, tx_do_wr, tx_drop;
  logic rx_do_pop, rx_do_wr, rx_drop, rx_match, rx_reject;
  logic [7:0] dst;

  function automatic logic [aw-1:0] next_ptr(input logic [aw-1:0] p);
    return (p == last_idx) ? '0 : p + 1'b1;
  endfunction

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == full_cnt);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == full_cnt);

  // A pop on a full FIFO frees the slot, so a simultaneous write is accepted.
  assign tx_do_pop = bus.pop & ~tx_empty;
  assign tx_do_wr  = bus.host_wr & (~tx_full | tx_do_pop);
  assign tx_drop   = bus.host_wr & ~tx_do_wr;

  assign dst       = bus.D_push[pckg_sz-1:pckg_sz-8];
  assign rx_match  = (dst == dev_id) || (dst == broadcast);
  assign rx_reject = bus.push & ~rx_match;
  assign rx_do_pop = bus.rx_ready & ~rx_empty;
  assign rx_do_wr  = bus.push & rx_match & (~rx_full | rx_do_pop);
  assign rx_drop   = bus.push & rx_match & ~rx_do_wr;

  // Outputs are gated by the occupancy count. Memory contents left over from
  // before a reset can therefore never appear on D_pop or rx_data.
  assign bus.pndng     = ~tx_empty;
  assign bus.host_full = tx_full;
  assign bus.D_pop     = tx_empty ? '0 : tx_mem[tx_rd_ptr];
  assign bus.rx_valid  = ~rx_empty;
  assign bus.rx_data   = rx_empty ? '0 : rx_mem[rx_rd_ptr];

  always_ff @(posedge clk) begin
    if (tx_do_wr) tx_mem[tx_wr_ptr] <= bus.host_wdata;
    if (rx_do_wr) rx_mem[rx_wr_ptr] <= bus.D_push;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_do_wr)  tx_wr_ptr <= next_ptr(tx_wr_ptr);
      if (tx_do_pop) tx_rd_ptr <= next_ptr(tx_rd_ptr);
      if (tx_do_wr && !tx_do_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_do_wr && tx_do_pop) tx_count <= tx_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_do_wr)  rx_wr_ptr <= next_ptr(rx_wr_ptr);
      if (rx_do_pop) rx_rd_ptr <= next_ptr(rx_rd_ptr);
      if (rx_do_wr && !rx_do_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_do_wr && rx_do_pop) rx_count <= rx_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf_cnt  <= '0;
      rx_ovf_cnt  <= '0;
      rx_filt_cnt <= '0;
    end else begin
      if (tx_drop   && tx_ovf_cnt  != 8'hFF) tx_ovf_cnt  <= tx_ovf_cnt  + 8'd1;
      if (rx_drop   && rx_ovf_cnt  != 8'hFF) rx_ovf_cnt  <= rx_ovf_cnt  + 8'd1;
      if (rx_reject && rx_filt_cnt != 8'hFF) rx_filt_cnt <= rx_filt_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_dev_port.sv
// Directed bench for bus_dev_port: a vector table plus hand-written FIFO-full,
// saturation and asynchronous-reset sequences.
module tb_bus_dev_port;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] tx_ovf_cnt, rx_ovf_cnt, rx_filt_cnt;
  int tests = 0;
  int fails = 0;

  bus_dev_port_if #(.pckg_sz(16)) bif ();

  bus_dev_port #(.pckg_sz(16), .depth(8), .dev_id(8'd2), .broadcast(8'hFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bif.slave),
    .tx_ovf_cnt  (tx_ovf_cnt),
    .rx_ovf_cnt  (rx_ovf_cnt),
    .rx_filt_cnt (rx_filt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] wdata;
    logic        pop;
    logic        push;
    logic [15:0] dpush;
    logic        rdy;
    logic        e_pndng;
    logic [15:0] e_dpop;
    logic        e_full;
    logic        e_rxv;
    logic [15:0] e_rxd;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bif.host_wr    = 1'b0;
    bif.host_wdata = 16'h0;
    bif.pop        = 1'b0;
    bif.push       = 1'b0;
    bif.D_push     = 16'h0;
    bif.rx_ready   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " pndng"},     32'(bif.pndng),     32'h0);
    chk({tag, " host_full"}, 32'(bif.host_full), 32'h0);
    chk({tag, " rx_valid"},  32'(bif.rx_valid),  32'h0);
    chk({tag, " D_pop"},     32'(bif.D_pop),     32'h0);
    chk({tag, " rx_data"},   32'(bif.rx_data),   32'h0);
    chk({tag, " tx_ovf"},    32'(tx_ovf_cnt),    32'h0);
    chk({tag, " rx_ovf"},    32'(rx_ovf_cnt),    32'h0);
    chk({tag, " rx_filt"},   32'(rx_filt_cnt),   32'h0);
  endtask

  initial begin
    //            wr    wdata     pop   push  dpush     rdy   pndng dpop      full  rxv   rxd
    vecs[0]  = '{1'b1, 16'h0201, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 16'h0302, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 16'h0403, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0302, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0403, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 16'h0501, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0501, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h02AA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02AA};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFBB, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02AA};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h03CC, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02AA};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFBB};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[15] = '{1'b1, 16'h0A0A, 1'b0, 1'b1, 16'h020B, 1'b0, 1'b1, 16'h0A0A, 1'b0, 1'b1, 16'h020B};
    vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};

    idle();
    reset = 1'b0;
    #3;
    chk_outputs_zero("reset");
    @(posedge clk);
    #3 reset = 1'b1;
    tick();

    // Table: TX ordering, empty-pop corners, RX filter, concurrent TX/RX.
    foreach (vecs[i]) begin
      bif.host_wr    = vecs[i].wr;
      bif.host_wdata = vecs[i].wdata;
      bif.pop        = vecs[i].pop;
      bif.push       = vecs[i].push;
      bif.D_push     = vecs[i].dpush;
      bif.rx_ready   = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d pndng", i),     32'(bif.pndng),     32'(vecs[i].e_pndng));
      chk($sformatf("vec%0d D_pop", i),     32'(bif.D_pop),     32'(vecs[i].e_dpop));
      chk($sformatf("vec%0d host_full", i), 32'(bif.host_full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d rx_valid", i),  32'(bif.rx_valid),  32'(vecs[i].e_rxv));
      chk($sformatf("vec%0d rx_data", i),   32'(bif.rx_data),   32'(vecs[i].e_rxd));
    end
    idle();
    chk("table rx_filt_cnt", 32'(rx_filt_cnt), 32'd1);
    chk("table tx_ovf_cnt",  32'(tx_ovf_cnt),  32'd0);
    chk("table rx_ovf_cnt",  32'(rx_ovf_cnt),  32'd0);

    // TX full, overflow, then write+pop while full.
    for (int i = 0; i < 8; i++) begin
      bif.host_wr = 1'b1; bif.host_wdata = 16'h1000 + 16'(i);
      tick();
    end
    chk("tx fill host_full", 32'(bif.host_full), 32'h1);
    for (int i = 0; i < 2; i++) begin
      bif.host_wr = 1'b1; bif.host_wdata = 16'hDEAD;
      tick();
    end
    chk("tx ovf cnt",       32'(tx_ovf_cnt),    32'd2);
    chk("tx ovf host_full", 32'(bif.host_full), 32'h1);
    chk("tx ovf head",      32'(bif.D_pop),     32'h1000);
    bif.host_wr = 1'b1; bif.host_wdata = 16'h2000; bif.pop = 1'b1;
    tick();
    idle();
    chk("tx wr+pop full host_full", 32'(bif.host_full), 32'h1);
    chk("tx wr+pop full ovf",       32'(tx_ovf_cnt),    32'd2);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp;
      exp = (i < 7) ? 16'h1001 + 16'(i) : 16'h2000;
      chk($sformatf("tx drain %0d", i), 32'(bif.D_pop), 32'(exp));
      bif.pop = 1'b1;
      tick();
    end
    idle();
    chk("tx drained pndng", 32'(bif.pndng), 32'h0);
    chk("tx drained D_pop", 32'(bif.D_pop), 32'h0);

    // RX overflow with rx_ready low, then push+consume while full.
    for (int i = 0; i < 10; i++) begin
      bif.push = 1'b1; bif.D_push = 16'h0200 + 16'(i);
      tick();
    end
    idle();
    chk("rx ovf rx_valid", 32'(bif.rx_valid), 32'h1);
    chk("rx ovf cnt",      32'(rx_ovf_cnt),   32'd2);
    chk("rx ovf head",     32'(bif.rx_data),  32'h0200);
    bif.push = 1'b1; bif.D_push = 16'h02EE; bif.rx_ready = 1'b1;
    tick();
    idle();
    chk("rx push+pop full ovf", 32'(rx_ovf_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp;
      exp = (i < 7) ? 16'h0201 + 16'(i) : 16'h02EE;
      chk($sformatf("rx drain %0d", i), 32'(bif.rx_data), 32'(exp));
      bif.rx_ready = 1'b1;
      tick();
    end
    idle();
    chk("rx drained rx_valid", 32'(bif.rx_valid), 32'h0);

    // Filter counter saturation (starts at 1 from the table).
    for (int k = 1; k <= 300; k++) begin
      bif.push = 1'b1; bif.D_push = 16'h0577;
      tick();
      if (k == 253) chk("filt before sat", 32'(rx_filt_cnt), 32'd254);
      if (k == 254) chk("filt at sat",     32'(rx_filt_cnt), 32'd255);
    end
    idle();
    chk("filt held sat",   32'(rx_filt_cnt),  32'd255);
    chk("filt rx_valid",   32'(bif.rx_valid), 32'h0);

    // Asynchronous reset with both FIFOs occupied.
    for (int i = 0; i < 5; i++) begin
      bif.host_wr = 1'b1; bif.host_wdata = 16'h0300 + 16'(i);
      bif.push = (i < 3); bif.D_push = 16'hFF40 + 16'(i);
      tick();
    end
    idle();
    chk("pre-reset pndng",    32'(bif.pndng),    32'h1);
    chk("pre-reset rx_valid", 32'(bif.rx_valid), 32'h1);
    #3 reset = 1'b0;
    #1;
    chk_outputs_zero("async reset");
    @(posedge clk);
    #3 reset = 1'b1;
    bif.host_wr = 1'b1; bif.host_wdata = 16'h0777;
    bif.push = 1'b1; bif.D_push = 16'hFF11;
    tick();
    idle();
    chk("post-reset pndng",    32'(bif.pndng),    32'h1);
    chk("post-reset D_pop",    32'(bif.D_pop),    32'h0777);
    chk("post-reset rx_valid", 32'(bif.rx_valid), 32'h1);
    chk("post-reset rx_data",  32'(bif.rx_data),  32'hFF11);
    chk("post-reset tx_ovf",   32'(tx_ovf_cnt),   32'h0);
    chk("post-reset filt",     32'(rx_filt_cnt),  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
